// File: rtl/cpu_lsu_pkg.sv
// cpu_lsu_pkg: shared types and widths for the load/store unit
package cpu_lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam int MEM_AW_DEF = 10;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
endpackage

// File: rtl/cpu_lsu_addr_check.sv
// cpu_lsu_addr_check: byte-address range check and word index; CPU_LSU_ALIGN_CHECK_EN adds alignment check
module cpu_lsu_addr_check
  import cpu_lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic [XLEN-1:0]   i_addr,
  output logic [MEM_AW-1:0] o_idx,
  output logic              o_ok
);
  logic w_in_range;
  assign w_in_range = i_addr[XLEN-1:MEM_AW+2] == '0;
  assign o_idx = i_addr[MEM_AW+1:2];
`ifdef CPU_LSU_ALIGN_CHECK_EN
  assign o_ok = w_in_range && (i_addr[1:0] == 2'b00);
`else
  logic w_unused;
  assign w_unused = ^i_addr[1:0];
  assign o_ok = w_in_range;
`endif
endmodule

// File: rtl/cpu_lsu.sv
// cpu_lsu: load/store unit, IDLE->ACCESS->RESP sequencer (alignment check via CPU_LSU_ALIGN_CHECK_EN)
module cpu_lsu
  import cpu_lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_writeen,
  output logic [XLEN-1:0]   mem_writeint,
  input  logic [XLEN-1:0]   mem_RD,
  output logic              wb_writeen,
  output logic [REG_AW-1:0] wb_addrw,
  output logic [XLEN-1:0]   wb_writeint,
  output logic              done,
  output logic              fault
);
  state_t            r_state;
  logic              r_store, r_fault;
  logic [MEM_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_data;
  logic [REG_AW-1:0] r_rd;
  logic              w_ok, w_accept;
  logic [MEM_AW-1:0] w_idx;

  cpu_lsu_addr_check #(.MEM_AW(MEM_AW)) u_chk (
    .i_addr(req_addr),
    .o_idx (w_idx),
    .o_ok  (w_ok)
  );

  assign req_ready    = r_state == S_IDLE;
  assign w_accept     = req_valid && req_ready;
  assign mem_addr     = r_addr;
  assign mem_writeen  = (r_state == S_ACCESS) && r_store;
  assign mem_writeint = r_wdata;
  assign done         = r_state == S_RESP;
  assign fault        = done && r_fault;
  assign wb_writeen   = done && !r_fault && !r_store && (r_rd != '0);
  assign wb_addrw     = r_rd;
  assign wb_writeint  = r_data;

  // Sequence one request: latch on accept, access memory, then report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_rd    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_store <= req_store;
          r_wdata <= req_wdata;
          r_rd    <= req_rd;
          r_fault <= !w_ok;
          if (w_ok) r_addr <= w_idx;
          r_state <= w_ok ? S_ACCESS : S_RESP;
        end
        S_ACCESS: begin
          if (!r_store) r_data <= mem_RD;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_lsu.sv
// tb_cpu_lsu: directed scoreboard bench for cpu_lsu with a behavioural data memory
module tb_cpu_lsu;
`ifdef CPU_LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {
    logic        fault;
    logic        store;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] wdata;
    logic [9:0]  idx;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, mem_writeen, wb_writeen, done, fault;
  logic [9:0]  mem_addr;
  logic [31:0] mem_writeint, mem_RD, wb_writeint;
  logic [4:0]  wb_addrw;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  exp_t        sb [$];
  int          checks = 0, passes = 0;

  cpu_lsu #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_writeen(mem_writeen), .mem_writeint(mem_writeint),
    .mem_RD(mem_RD), .wb_writeen(wb_writeen), .wb_addrw(wb_addrw),
    .wb_writeint(wb_writeint), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;
  assign mem_RD = mem[mem_addr];
  always @(posedge clk) if (mem_writeen) mem[mem_addr] <= mem_writeint;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    exp_t e;
    bit   got = 0;
    int   lat = 0, wr_cnt = 0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    e.fault = !((a[31:12] == 20'd0) && (!ALIGN || a[1:0] == 2'b00));
    e.store = st;
    e.wen   = !e.fault && !st && rd != 5'd0;
    e.rd    = rd;
    e.idx   = a[11:2];
    e.data  = ref_mem[a[11:2]];
    e.wdata = wd;
    if (!e.fault && st) ref_mem[a[11:2]] = wd;
    sb.push_back(e);
    @(negedge clk);
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = ~st; req_addr = ~a; req_wdata = ~wd; req_rd = ~rd;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (mem_writeen) begin
        wr_cnt++; wr_addr = mem_addr; wr_data = mem_writeint;
      end
      if (done) begin
        got = 1; lat = c;
      end else chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
    end
    if (!got || sb.size() == 0) chk("done_timeout", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk("latency", lat, e.fault ? 32'd1 : 32'd2);
      chk("fault", {31'd0, fault}, {31'd0, e.fault});
      chk("wb_writeen", {31'd0, wb_writeen}, {31'd0, e.wen});
      if (e.wen) begin
        chk("wb_addrw", {27'd0, wb_addrw}, {27'd0, e.rd});
        chk("wb_writeint", wb_writeint, e.data);
      end
      chk("mem_write_count", wr_cnt, (e.store && !e.fault) ? 32'd1 : 32'd0);
      if (e.store && !e.fault) begin
        chk("mem_write_addr", {22'd0, wr_addr}, {22'd0, e.idx});
        chk("mem_write_data", wr_data, e.wdata);
      end
      @(negedge clk);
      chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'd0; ref_mem[i] = 32'd0;
    end
    mem[1] = 32'd7; ref_mem[1] = 32'd7;
    mem[3] = 32'h33; ref_mem[3] = 32'h33;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_writeen}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_writeen}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wb_data", wb_writeint, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h4, 32'h0, 5'd3);
    do_req(1'b1, 32'h8, 32'hDEADBEEF, 5'd9);
    do_req(1'b0, 32'h8, 32'h0, 5'd5);
    do_req(1'b0, 32'h1000, 32'h0, 5'd4);
    do_req(1'b1, 32'h8000_0010, 32'h5555AAAA, 5'd0);
    do_req(1'b0, 32'h6, 32'h0, 5'd7);
    do_req(1'b0, 32'h4, 32'h0, 5'd0);
    do_req(1'b1, 32'hFFC, 32'hCAFEF00D, 5'd1);
    do_req(1'b0, 32'hFFC, 32'h0, 5'd31);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_addr = 32'hC; req_wdata = 32'h12345678; req_rd = 5'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("access_we_before_reset", {31'd0, mem_writeen}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_we", {31'd0, mem_writeen}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    @(negedge clk);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mem3_unchanged", mem[3], 32'h33);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'hC, 32'h0, 5'd2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
